// File: rtl/fir_queue_pkg.sv
// fir_queue_pkg: shared types and defaults for the stereo FIR sample queue
package fir_queue_pkg;
  localparam int DEPTH_DEF = 1024;
  localparam int TAPS_DEF  = 1021;
  typedef logic [$clog2(DEPTH_DEF)-1:0] ptr_t;
  typedef enum logic [1:0] {IDLE, READ, DRAIN} q_state_t;
  typedef struct packed {
    logic [15:0] lft;
    logic [15:0] rght;
  } smpl_pair_t;
endpackage

// File: rtl/fir_sample_queue_if.sv
// fir_sample_queue_if: sample capture input and sequencing replay stream
interface fir_sample_queue_if;
  logic        wrt_smpl;
  logic [15:0] lft_smpl;
  logic [15:0] rght_smpl;
  logic        sequencing;
  logic [15:0] lft_out;
  logic [15:0] rght_out;
  modport master (
    input  wrt_smpl, lft_smpl, rght_smpl,
    output sequencing, lft_out, rght_out
  );
  modport slave (
    output wrt_smpl, lft_smpl, rght_smpl,
    input  sequencing, lft_out, rght_out
  );
endinterface

// File: rtl/fir_sample_queue_dpram_stereo.sv
// dpram_stereo: DEPTHx32 simple dual-port RAM, 1-cycle read, read-before-write
module dpram_stereo
  import fir_queue_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  smpl_pair_t               wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output smpl_pair_t               rdata
);
  smpl_pair_t mem [DEPTH];
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end
endmodule

// File: rtl/fir_sample_queue.sv
// fir_sample_queue: stereo circular queue replaying the last TAPS samples oldest-first.
// FIR_QUEUE_OVERLAP_EN: strobes during a replay queue one follow-on replay.
module fir_sample_queue
  import fir_queue_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF,
  parameter int TAPS  = TAPS_DEF
) (
  input logic                 clk,
  input logic                 rst_n,
  fir_sample_queue_if.master  q
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(TAPS + 1);
  q_state_t state, state_nxt;
  logic [AW-1:0] new_ptr, rd_ptr, rd_ptr_nxt, load_ptr;
  logic [CW-1:0] fill_cnt, fill_nxt, rd_cnt, rd_cnt_nxt;
  logic rd_vld, drain_go;
  smpl_pair_t wdata, rdata;
  assign wdata = '{lft: q.lft_smpl, rght: q.rght_smpl};
  // oldest of the last TAPS samples, counting a write landing this cycle
  assign load_ptr = new_ptr + AW'(q.wrt_smpl) - AW'(TAPS);
  assign fill_nxt = (q.wrt_smpl && fill_cnt != CW'(TAPS)) ? fill_cnt + 1'b1 : fill_cnt;
`ifdef FIR_QUEUE_OVERLAP_EN
  logic pend;
  assign drain_go = pend | q.wrt_smpl;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) pend <= 1'b0;
    else pend <= (state == READ) ? (pend | q.wrt_smpl) : 1'b0;
`else
  assign drain_go = 1'b0;
`endif
  always_comb begin
    state_nxt  = state;
    rd_ptr_nxt = rd_ptr;
    rd_cnt_nxt = '0;
    state_nxt  = (state == IDLE)  ? ((q.wrt_smpl && fill_nxt == CW'(TAPS)) ? READ : IDLE) :
                 (state == READ)  ? ((rd_cnt == CW'(TAPS - 1)) ? DRAIN : READ) :
                 (drain_go ? READ : IDLE);
    rd_ptr_nxt = (state == READ) ? rd_ptr + 1'b1 :
                 (state_nxt == READ) ? load_ptr : rd_ptr;
    rd_cnt_nxt = (state == READ) ? rd_cnt + 1'b1 : '0;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state    <= IDLE;
      new_ptr  <= '0;
      rd_ptr   <= '0;
      rd_cnt   <= '0;
      fill_cnt <= '0;
    end else begin
      state    <= state_nxt;
      new_ptr  <= new_ptr + AW'(q.wrt_smpl);
      rd_ptr   <= rd_ptr_nxt;
      rd_cnt   <= rd_cnt_nxt;
      fill_cnt <= fill_nxt;
    end
  dpram_stereo #(.DEPTH(DEPTH)) u_ram (
    .clk   (clk),
    .we    (q.wrt_smpl),
    .waddr (new_ptr),
    .wdata (wdata),
    .raddr (rd_ptr),
    .rdata (rdata)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      rd_vld       <= 1'b0;
      q.sequencing <= 1'b0;
      q.lft_out    <= '0;
      q.rght_out   <= '0;
    end else begin
      rd_vld       <= (state == READ);
      q.sequencing <= rd_vld;
      q.lft_out    <= rd_vld ? rdata.lft : '0;
      q.rght_out   <= rd_vld ? rdata.rght : '0;
    end
endmodule

// File: doc/fir_sample_queue.md
# fir_sample_queue

Stereo circular sample queue that feeds the FIR filter bands. It stores each new left/right audio sample and, once TAPS samples are held, replays the most recent TAPS samples oldest-to-newest. The replay runs one sample per clock under a `sequencing` window. It is the producer end of the `sequencing` / sample-stream interface that every FIR band consumes, and sits between the codec sample capture and the filter bank.

## Interface
Parameters:
- DEPTH, 1024: queue entries per channel; must be a power of 2.
- TAPS, 1021: samples replayed per window; TAPS ≤ DEPTH−1.

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset, asynchronous, active-low
- wrt_smpl  in  1  one-cycle strobe: new sample pair valid
- lft_smpl  in  16  signed left sample
- rght_smpl  in  16  signed right sample
- sequencing  out  1  high for exactly TAPS consecutive cycles per replay
- lft_out  out  16  replayed left sample
- rght_out  out  16  replayed right sample

## Operation
- Storage: one DEPTH×32 synchronous dual-port RAM, entry = {lft,rght}. The RAM is not reset.
- Write side:
  - When wrt_smpl is high, write {lft_smpl,rght_smpl} at new_ptr, then new_ptr ← new_ptr+1 mod DEPTH.
  - A write is always accepted, including during replay.
- fill_cnt counts writes since reset and saturates at TAPS.
- FSM states:
  - IDLE:
    - On wrt_smpl, if the post-write fill_cnt equals TAPS, go to READ.
    - On entry to READ, load rd_ptr = (new_ptr − (TAPS−1)) mod DEPTH, using new_ptr before the increment. This is the oldest of the last TAPS samples, including the one just written.
  - READ:
    - Issue a RAM read at rd_ptr each cycle and increment rd_ptr mod DEPTH.
    - After TAPS reads, go to DRAIN.
  - DRAIN: one cycle to flush the RAM latency, then go to IDLE.
    - With FIR_QUEUE_OVERLAP_EN and pend set, go to READ instead, with rd_ptr reloaded from the current new_ptr.
- Outputs:
  - Registered from the RAM read data.
  - Forced to 0 whenever sequencing is low.
- Replay order: cycle k of the window (k = 0..TAPS−1) presents sample k, oldest first. The last cycle presents the sample whose wrt_smpl triggered the replay.
- Pointer arithmetic: log2(DEPTH) bits with natural wrap. No sample is ever altered or scaled.
- Reset mid-operation:
  - Aborts immediately: sequencing=0, outputs 0, state IDLE.
  - new_ptr=0, fill_cnt=0.
  - TAPS fresh samples are required before the next replay.

## Timing
- Reset values: sequencing=0, lft_out=0, rght_out=0, state IDLE, new_ptr=0, rd_ptr=0, fill_cnt=0, pend=0.
- Latency: wrt_smpl sampled at edge E0.
  - sequencing rises after edge E2.
  - The first (oldest) sample is valid in that same cycle.
  - sequencing falls after edge E2+TAPS.
- The window is contiguous: no gaps, exactly TAPS cycles high. sequencing is low for at least 1 cycle between windows.
- wrt_smpl in the same cycle as a replay read of the same address: the read returns old data (read-before-write). The replay contents are unaffected because the written slot is never inside the current window when TAPS ≤ DEPTH−1.
- wrt_smpl while the FSM is not IDLE is handled per the Configuration section.

## Configuration
- FIR_QUEUE_OVERLAP_EN defined:
  - wrt_smpl during READ/DRAIN sets pend.
  - A follow-on replay of the latest TAPS samples starts directly from DRAIN, clearing pend.
  - Multiple strobes collapse into one pending replay.
- Not defined:
  - wrt_smpl during READ/DRAIN writes only and never triggers a replay.
  - The pend register does not exist.

## Structure
- Package fir_queue_pkg:
  - DEPTH_DEF and TAPS_DEF constants.
  - ptr_t (logic [$clog2(DEPTH_DEF)-1:0]).
  - Enum q_state_t {IDLE, READ, DRAIN}.
  - smpl_pair_t packed struct {lft, rght}.
- Sub-module dpram_stereo: DEPTH×32 simple dual-port RAM, 1 write port, 1 read port, 1-cycle read latency, read-before-write.

## Test plan
- Reset, then 1020 strobes → sequencing never rises. Strobe 1021 (sample values = index n, L=n, R=−n) → sequencing high for exactly 1021 cycles starting 2 cycles later; outputs L=1..1021 in order, R=−1..−1021.
- Continue with strobe 1022 after the window closes → replay L=2..1022; repeat past 1024 writes to prove pointer wrap (window spans addresses 1023→0).
- Assert rst_n low mid-window (cycle 500) → sequencing and outputs 0 immediately. 1021 new strobes are needed before the next window.
- Strobe during the window at cycle 300:
  - Without FIR_QUEUE_OVERLAP_EN: exactly one window, and the next strobe's replay includes the sample.
  - With FIR_QUEUE_OVERLAP_EN: a second 1021-cycle window follows after a 1-cycle gap, ending with that sample.
- Outputs checked to be 0 on every cycle where sequencing is low, across all scenarios.
